// File: rtl/ahb_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_pkg
//  Purpose  : Shared AHB-Lite encodings (HTRANS, HSIZE, HRESP), the SRAM
//             slave FSM state type and a byte-lane helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_lite_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    localparam logic [2:0] c_hsize_byte = 3'd0;
    localparam logic [2:0] c_hsize_half = 3'd1;
    localparam logic [2:0] c_hsize_word = 3'd2;

    localparam logic [1:0] c_hresp_okay  = 2'b00;
    localparam logic [1:0] c_hresp_error = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } sram_state_t;

    // Little-endian byte lanes. Misaligned low bits are ignored: a half uses
    // addr[1] only, and anything wider than a half writes the whole word.
    function automatic logic [3:0] lane_enable(input logic [2:0] size,
                                               input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            c_hsize_byte: be = 4'b0001 << lo;
            c_hsize_half: be = lo[1] ? 4'b1100 : 4'b0011;
            default:      be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_s2_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_s2_mem
//  Purpose  : Word-organised storage array with per-byte write enables,
//             synchronous write and asynchronous read. No reset.
//  Ports    : clk      - clock
//             i_be     - byte-lane write enables (4)
//             i_waddr  - write word address
//             i_wdata  - write data (32)
//             i_raddr  - read word address
//             o_rdata  - read data (32), combinational from i_raddr
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_s2_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ahb_sram_s2.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_s2
//  Purpose  : AHB-Lite on-chip SRAM slave for interconnect slot s2, with a
//             configurable number of wait states per OKAY data phase.
//  Macro    : AHB_SRAM_S2_RANGE_CHECK_EN - when defined, oversized,
//             misaligned or out-of-range accesses get a two-cycle ERROR
//             response and no memory effect.
//  Ports    : HCLK, HRESETn          - clock, async active-low reset
//             hsel_s2, haddr_s,
//             htrans_s, hwrite_s,
//             hsize_s, hwdata_s      - shared slave-side bus inputs
//             HREADY                 - bus-level ready
//             hready_resp_s2         - slave ready
//             hresp_s2               - OKAY/ERROR
//             hrdata_s2              - read data
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_s2
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        hsel_s2,
    input  logic [31:0] haddr_s,
    input  logic [1:0]  htrans_s,
    input  logic        hwrite_s,
    input  logic [2:0]  hsize_s,
    input  logic [31:0] hwdata_s,
    input  logic        HREADY,
    output logic        hready_resp_s2,
    output logic [1:0]  hresp_s2,
    output logic [31:0] hrdata_s2
);

    localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    sram_state_t       r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_dp_valid, w_dp_valid_nxt;   // legal data phase in flight
    logic              r_write;
    logic [ADDR_W-1:0] r_waddr;
    logic [3:0]        r_be;

    logic              w_ready;
    logic              w_sample;
    logic              w_illegal;
    logic              w_legal;
    logic              w_bad;
    logic [3:0]        w_be;
    logic [31:0]       w_rdata;
    logic              w_unused_bits;

    // A new address phase can only be taken while this slave is not
    // stalling the bus (IDLE or the final ERROR cycle).
    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign w_sample = hsel_s2 & htrans_s[1] & HREADY & w_ready;

`ifdef AHB_SRAM_S2_RANGE_CHECK_EN
    assign w_illegal = (hsize_s > c_hsize_word)
                     | ((hsize_s == c_hsize_half) & haddr_s[0])
                     | ((hsize_s == c_hsize_word) & (|haddr_s[1:0]))
                     | (|(haddr_s[15:0] >> (ADDR_W + 2)));
`else
    assign w_illegal = 1'b0;
`endif

    assign w_legal = w_sample & ~w_illegal;
    assign w_bad   = w_sample &  w_illegal;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_dp_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dp_valid <= w_dp_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dp_valid_nxt = r_dp_valid;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_dp_valid_nxt = w_legal;
                w_cnt_nxt      = 4'd0;
                if (w_bad) begin
                    w_state_nxt = ST_ERR1;
                end else if (w_legal && (WAIT_STATES > 0)) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = c_wait_load;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The cycle after the last WAIT (back in IDLE) is the
                // completing ready-high cycle of the data phase.
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address-phase controls; lane enables are resolved at sample time so
    // the data phase only needs to gate them.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_write <= 1'b0;
            r_waddr <= '0;
            r_be    <= 4'd0;
        end else if (w_sample) begin
            r_write <= hwrite_s;
            r_waddr <= haddr_s[ADDR_W+1:2];
            r_be    <= lane_enable(hsize_s, haddr_s[1:0]);
        end
    end

    // Commit only on the ready-high cycle ending a legal write data phase;
    // a reset before that cycle clears r_dp_valid and drops the write.
    assign w_be = (r_dp_valid & r_write & w_ready) ? r_be : 4'd0;

    ahb_sram_s2_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (HCLK),
        .i_be    (w_be),
        .i_waddr (r_waddr),
        .i_wdata (hwdata_s),
        .i_raddr (r_waddr),
        .o_rdata (w_rdata)
    );

    assign hready_resp_s2 = w_ready;
    assign hrdata_s2      = (r_dp_valid & ~r_write) ? w_rdata : 32'h0;

`ifdef AHB_SRAM_S2_RANGE_CHECK_EN
    assign hresp_s2 = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? c_hresp_error
                                                                      : c_hresp_okay;
`else
    assign hresp_s2 = c_hresp_okay;
`endif

    // Address bits above the array and HTRANS[0] carry no meaning here.
    assign w_unused_bits = ^{htrans_s[0], haddr_s};

endmodule
`default_nettype wire

// File: doc/ahb_sram_s2.md
# ahb_sram_s2

AHB-Lite on-chip SRAM slave for interconnect slot s2. It consumes the shared slave-side bus (`haddr_s`, `htrans_s`, `hwrite_s`, `hsize_s`, `hwdata_s`) and the `hsel_s2` select, and returns `hready_resp_s2`, `hresp_s2` and `hrdata_s2` to the AHB-Lite interconnect. It provides a word-organised, byte-writable scratch memory with a configurable number of wait states. Optionally, it returns a two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address bits; depth is 2^ADDR_W words (4 KB at default); legal range 4..14.
- `WAIT_STATES`, default 1: wait cycles inserted in every OKAY data phase; legal range 0..15.

Ports:
- `HCLK`  in  1  bus clock; the only clock.
- `HRESETn`  in  1  asynchronous, active-low reset.
- `hsel_s2`  in  1  slot select from the interconnect.
- `haddr_s`  in  32  byte address.
- `htrans_s`  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- `hwrite_s`  in  1  1 = write.
- `hsize_s`  in  3  0 = byte, 1 = half, 2 = word.
- `hwdata_s`  in  32  write data (data phase).
- `HREADY`  in  1  bus-level ready.
- `hready_resp_s2`  out  1  slave ready.
- `hresp_s2`  out  2  OKAY = 2'b00, ERROR = 2'b01.
- `hrdata_s2`  out  32  read data.

## Operation
- **Address-phase sample**: `hsel_s2 & htrans_s[1] & HREADY`. On a sample, register the address, write flag and size, and assess legality.
- Sel with IDLE/BUSY, or no sel: zero-wait OKAY, no memory effect.
- **FSM states**: IDLE, WAIT, ERR1, ERR2.
  - IDLE to WAIT: legal sample with WAIT_STATES > 0. The wait counter loads WAIT_STATES−1.
  - IDLE to IDLE: legal sample with WAIT_STATES = 0. Data phase completes in the next cycle with ready high.
  - WAIT: `hready_resp_s2` = 0. The counter decrements and the FSM exits when the counter reaches 0. The completing cycle has ready = 1.
  - IDLE to ERR1: illegal sample (macro only).
  - ERR1: ready = 0, ERROR. Always moves to ERR2.
  - ERR2: ready = 1, ERROR. A new address phase may be sampled in this cycle and is handled like any sample from IDLE.
- **Writes**: byte lanes are committed at the clock edge ending the data phase (ready = 1 cycle), using `hwdata_s`. Lane rules, little-endian only:
  - byte: lane `addr[1:0]`.
  - half: lanes `{addr[1],0}` and `{addr[1],1}`.
  - word: all lanes.
- **Reads**: `hrdata_s2` = mem[registered word address] during a read data phase, otherwise 32'h0. Full words are always returned; the master extracts the lanes.
- **Back-to-back**: pipelined. The next address is sampled in the same cycle the current data phase completes. A read that follows a write to the same word returns the new data.
- **Reset mid-transfer**: the FSM goes to IDLE and all outputs return to their reset values. Memory contents are not cleared. An in-flight write is dropped.
- **Write to an illegal access**: no memory effect.

## Timing
- **Reset values**: `hready_resp_s2` = 1, `hresp_s2` = 2'b00, `hrdata_s2` = 32'h0, FSM in IDLE, counter at 0.
- **OKAY latency**: data phase = WAIT_STATES + 1 cycles after the address phase.
- **ERROR**: exactly 2 cycles, regardless of WAIT_STATES.
- All outputs are driven from registered state, or from the registered address through the array. There is no combinational path from `haddr_s` to any output.

## Configuration
- Macro: `AHB_SRAM_S2_RANGE_CHECK_EN`.
- **Defined**: an access is illegal if any of the following hold:
  - `hsize_s` > 2;
  - it is misaligned (half with `addr[0]` = 1; word with `addr[1:0]` ≠ 0);
  - `haddr_s[15:ADDR_W+2]` ≠ 0.

  Illegal accesses take the ERR1/ERR2 path.
- **Undefined**: no checks, ERR states are unreachable, and `hresp_s2` is constant 2'b00.
  - The address wraps modulo the depth.
  - Misaligned low bits are ignored for lane selection: half uses `addr[1]`, word uses all lanes.
  - `hsize_s` > 2 is treated as a word.

## Structure
- **Shared package `ahb_lite_pkg`**:
  - HTRANS encodings;
  - HSIZE encodings;
  - HRESP encodings (OKAY/ERROR);
  - the FSM state typedef.
- **Sub-module `ahb_sram_s2_mem`**: the storage array. It has a synchronous write with a 4-bit byte-enable and an asynchronous read; it has no reset.

## Test plan
- Word write 0xDEADBEEF to 0x0010, then read 0x0010. With WAIT_STATES = 1, each data phase shows ready low for 1 cycle, then high with OKAY; the read returns 0xDEADBEEF.
- Byte writes of 0x11, 0x22, 0x33, 0x44 to 0x20..0x23 issued back-to-back, then a word read of 0x20 returns 0x44332211, with no dead cycles between data phases.
- With WAIT_STATES = 0, a NONSEQ write and then a read to the same address complete in 2 consecutive cycles; the read returns the written data.
- With the macro on, a word access to 0x0002 gives ready = 0/ERROR, then ready = 1/ERROR, and memory is unchanged. An access to 0x4000 at ADDR_W = 10 behaves the same way.
- Assert `HRESETn` during a WAIT cycle of a write. Outputs return to 1/00/0 asynchronously, the target word keeps its old value, and the next transfer behaves normally.
- `hsel_s2` with `htrans_s` = IDLE and BUSY produces a zero-wait OKAY and no memory change.
